load_store_unit: RTL

//   Memory-access stage directly downstream of the core datapath.
//   - Consumes the datapath's ALU result (address), store data (memin) and byte mask (iobytes).
//   - Runs a req/ack handshake on a 32-bit word-addressed data bus, steering byte lanes both ways.
//   - Returns right-aligned load data; the datapath sign/zero-extends it as memout.
//   - Stalls the core until the access completes, faults or times out.

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-access stage. Runs a req/ack word bus with byte-lane
//             steering and stalls the core until the access retires.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  iobytes,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_err,
    output logic [31:0] bus_addr,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_count;
    logic [1:0]  r_sh;
    logic [3:0]  r_size;
    logic        r_bus_rd;
    logic        r_bus_wr;
    logic        r_bus_err;
    logic [31:0] r_rdata;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;

    logic [3:0]  w_size;
    logic        w_req;
    logic        w_idle;
    logic        w_misaligned;
    logic        w_start;
    logic [31:0] w_lane_mask;
    logic [31:0] w_rdata_lanes;

    // Anything other than byte or half is handled as a full word.
    always_comb begin
        w_size = 4'b1111;
        case (iobytes)
            4'b0001: w_size = 4'b0001;
            4'b0011: w_size = 4'b0011;
            default: w_size = 4'b1111;
        endcase
    end

    assign w_req        = req_read | req_write;
    assign w_idle       = (r_state == c_IDLE);
    assign w_misaligned = ((w_size == 4'b0011) && addr[0]) ||
                          ((w_size == 4'b1111) && (addr[1:0] != 2'b00));

    // Gating with rst keeps stall low for the whole reset pulse, even with req held.
    assign w_start = ~rst & w_idle & w_req & ~w_misaligned;
    assign fault   = ~rst & w_idle & w_req &  w_misaligned;
    assign stall   = w_start | (r_state == c_ACCESS);

    assign w_lane_mask   = {{8{r_size[3]}}, {8{r_size[2]}}, {8{r_size[1]}}, {8{r_size[0]}}};
    assign w_rdata_lanes = (bus_rdata >> {r_sh, 3'b000}) & w_lane_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_count     <= 8'd0;
            r_sh        <= 2'd0;
            r_size      <= 4'd0;
            r_bus_rd    <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_rdata     <= 32'd0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_start) begin
                        r_state     <= c_ACCESS;
                        r_count     <= 8'd0;
                        r_sh        <= addr[1:0];
                        r_size      <= w_size;
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_be    <= w_size << addr[1:0];
                        r_bus_wdata <= wdata << {addr[1:0], 3'b000};
                        r_bus_rd    <= ~req_write;
                        r_bus_wr    <= req_write;
                    end
                end
                c_ACCESS: begin
                    // An ack arriving on the last allowed cycle still wins over the timeout.
                    if (bus_ack || (r_count == c_TIMEOUT_LAST)) begin
                        r_state  <= c_DONE;
                        r_bus_rd <= 1'b0;
                        r_bus_wr <= 1'b0;
                        if (bus_ack) begin
                            if (r_bus_rd) begin
                                r_rdata <= w_rdata_lanes;
                            end
                        end else begin
                            r_bus_err <= 1'b1;
                            if (r_bus_rd) begin
                                r_rdata <= 32'd0;
                            end
                        end
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;
    assign bus_addr  = r_bus_addr;
    assign bus_rd    = r_bus_rd;
    assign bus_wr    = r_bus_wr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire
